// File: rtl/muldiv_pkg.sv
// Shared types and constants for the sequential multiply/divide unit.
// MULDIV_SIGNED_EN (optional) adds signed operation; see muldiv_seq.
package muldiv_pkg;
   localparam int DEF_WIDTH = 16;

   localparam logic OP_MUL = 1'b0;
   localparam logic OP_DIV = 1'b1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;
endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between the ALU (master) and muldiv_seq (slave).
// op_signed exists only when MULDIV_SIGNED_EN is defined.
interface muldiv_if #(
   parameter int WIDTH = 16
) ();
`ifdef MULDIV_SIGNED_EN
   logic             op_signed;
`endif
   logic             start;
   logic             op;
   logic [WIDTH-1:0] operand_a;
   logic [WIDTH-1:0] operand_b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result_hi;
   logic [WIDTH-1:0] result_lo;
   logic             div_zero;

   modport master (
`ifdef MULDIV_SIGNED_EN
      output op_signed,
`endif
      output start, op, operand_a, operand_b,
      input  busy, done, result_hi, result_lo, div_zero
   );

   modport slave (
`ifdef MULDIV_SIGNED_EN
      input  op_signed,
`endif
      input  start, op, operand_a, operand_b,
      output busy, done, result_hi, result_lo, div_zero
   );
endinterface

// File: rtl/muldiv_step.sv
// One combinational iteration: radix-2 shift-add multiply or restoring divide.
// hi/lo hold acc_hi/acc_lo for MUL and rem/quo for DIV; opd is multiplicand or divisor.
module muldiv_step
   import muldiv_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             op,
   input  logic [WIDTH-1:0] hi,
   input  logic [WIDTH-1:0] lo,
   input  logic [WIDTH-1:0] opd,
   output logic [WIDTH-1:0] hi_nxt,
   output logic [WIDTH-1:0] lo_nxt
);
   logic [WIDTH:0] sum;
   logic [WIDTH:0] trial;
   logic [WIDTH:0] diff;

   always_comb begin
      sum   = {1'b0, hi} + (lo[0] ? {1'b0, opd} : {(WIDTH+1){1'b0}});
      trial = {hi, lo[WIDTH-1]};
      diff  = trial - {1'b0, opd};
      hi_nxt = hi;
      lo_nxt = lo;
      if (op == OP_MUL) begin
         // carry re-enters at the top as the whole triple shifts right
         hi_nxt = sum[WIDTH:1];
         lo_nxt = {sum[0], lo[WIDTH-1:1]};
      end else if (!diff[WIDTH]) begin
         hi_nxt = diff[WIDTH-1:0];
         lo_nxt = {lo[WIDTH-2:0], 1'b1};
      end else begin
         hi_nxt = trial[WIDTH-1:0];
         lo_nxt = {lo[WIDTH-2:0], 1'b0};
      end
   end
endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle multiply/divide unit with start/busy/done handshake.
// Define MULDIV_SIGNED_EN to add op_signed (sign-magnitude wrap around the unsigned core).
module muldiv_seq
   import muldiv_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = 5
) (
   input  logic    clk,
   input  logic    rst_n,
   muldiv_if.slave bus
);
   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt;
   logic             accept, load;
   logic             op_q, dz_q, neg_res_q, neg_rem_q;
   logic [WIDTH-1:0] hi_q, lo_q, opd_q;
   logic [WIDTH-1:0] hi_nxt, lo_nxt;
   logic [WIDTH-1:0] fin_hi, fin_lo;
   logic [WIDTH-1:0] mag_a, mag_b;
   logic             sgn_in, dz_in;
   logic             done_q, div_zero_q;
   logic [WIDTH-1:0] res_hi_q, res_lo_q;

   function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x, input logic en);
      return en ? WIDTH'(-x) : x;
   endfunction

   function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] x, input logic en);
      return en ? (2*WIDTH)'(-x) : x;
   endfunction

`ifdef MULDIV_SIGNED_EN
   assign sgn_in = bus.op_signed;
`else
   assign sgn_in = 1'b0;
`endif

   assign dz_in = (bus.op == OP_DIV) && (bus.operand_b == '0);
   assign mag_a = neg_w(bus.operand_a, sgn_in && bus.operand_a[WIDTH-1]);
   assign mag_b = neg_w(bus.operand_b, sgn_in && bus.operand_b[WIDTH-1]);

   always_ff @(posedge clk) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      load      = 1'b0;
      case (state)
         S_IDLE: if (bus.start) begin
            accept    = 1'b1;
            state_nxt = dz_in ? S_DONE : S_RUN;
         end
         S_RUN:  if (cnt == '0) state_nxt = S_DONE;
         S_DONE: begin
            load      = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // control and architecturally visible results
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt        <= '0;
         op_q       <= OP_MUL;
         dz_q       <= 1'b0;
         neg_res_q  <= 1'b0;
         neg_rem_q  <= 1'b0;
         done_q     <= 1'b0;
         div_zero_q <= 1'b0;
         res_hi_q   <= '0;
         res_lo_q   <= '0;
      end else begin
         done_q <= load;
         if (accept) begin
            cnt        <= CNT_W'(WIDTH-1);
            op_q       <= bus.op;
            dz_q       <= dz_in;
            neg_res_q  <= sgn_in && (bus.operand_a[WIDTH-1] ^ bus.operand_b[WIDTH-1]);
            neg_rem_q  <= sgn_in && bus.operand_a[WIDTH-1];
            div_zero_q <= 1'b0;
         end else if (state == S_RUN && cnt != '0) begin
            cnt <= cnt - 1'b1;
         end
         if (load) begin
            div_zero_q <= dz_q;
            res_hi_q   <= fin_hi;
            res_lo_q   <= fin_lo;
         end
      end
   end

   // iteration registers need no reset: they are reloaded on every accept
   always_ff @(posedge clk) begin
      if (accept) begin
         if (dz_in) begin
            hi_q  <= bus.operand_a;
            lo_q  <= '1;
            opd_q <= bus.operand_b;
         end else if (bus.op == OP_MUL) begin
            hi_q  <= '0;
            lo_q  <= mag_b;
            opd_q <= mag_a;
         end else begin
            hi_q  <= '0;
            lo_q  <= mag_a;
            opd_q <= mag_b;
         end
      end else if (state == S_RUN) begin
         hi_q <= hi_nxt;
         lo_q <= lo_nxt;
      end
   end

   muldiv_step #(.WIDTH(WIDTH)) u_step (
      .op     (op_q),
      .hi     (hi_q),
      .lo     (lo_q),
      .opd    (opd_q),
      .hi_nxt (hi_nxt),
      .lo_nxt (lo_nxt)
   );

   always_comb begin
      fin_hi = hi_q;
      fin_lo = lo_q;
      if (!dz_q) begin
         if (op_q == OP_MUL) begin
            {fin_hi, fin_lo} = neg_2w({hi_q, lo_q}, neg_res_q);
         end else begin
            fin_hi = neg_w(hi_q, neg_rem_q);
            fin_lo = neg_w(lo_q, neg_res_q);
         end
      end
   end

   assign bus.busy      = (state != S_IDLE);
   assign bus.done      = done_q;
   assign bus.div_zero  = div_zero_q;
   assign bus.result_hi = res_hi_q;
   assign bus.result_lo = res_lo_q;
endmodule

// File: tb/tb_muldiv_seq.sv
// Directed plus randomized bench for muldiv_seq against an arithmetic reference model.
module tb_muldiv_seq;
   import muldiv_pkg::*;

   localparam int W = 16;

   logic clk;
   logic rst_n;
   int   vectors     = 0;
   int   miscompares = 0;

   muldiv_if #(.WIDTH(W)) bus ();

   muldiv_seq #(.WIDTH(W), .CNT_W(5)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference: plain integer arithmetic; SV division truncates toward zero
   // and the remainder follows the dividend's sign, as the unit requires.
   task automatic model(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sgn, output logic [31:0] r, output logic z);
      longint sa, sb, q, m;
      sa = sgn ? longint'($signed(a)) : longint'(a);
      sb = sgn ? longint'($signed(b)) : longint'(b);
      z  = (op == OP_DIV) && (b == 0);
      if (op == OP_MUL) begin
         m = sa * sb;
         r = 32'(m);
      end else if (z) begin
         r = {a, 16'hFFFF};
      end else begin
         q = sa / sb;
         m = sa % sb;
         r = {16'(m), 16'(q)};
      end
   endtask

   task automatic run_op(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic sgn, input int glitch_at);
      logic [31:0] exp_r;
      logic        exp_z;
      int          lat, n;
      model(op, a, b, sgn, exp_r, exp_z);
      lat = exp_z ? 1 : W + 1;
      @(negedge clk);
      bus.start     = 1'b1;
      bus.op        = op;
      bus.operand_a = a;
      bus.operand_b = b;
`ifdef MULDIV_SIGNED_EN
      bus.op_signed = sgn;
`endif
      @(posedge clk); #1;
      bus.start = 1'b0;
      chk("busy_after_accept", 32'(bus.busy), 32'd1);
      chk("div_zero_cleared", 32'(bus.div_zero), 32'd0);
      n = 0;
      while (n < 40) begin
         @(posedge clk); n++; #1;
         bus.start = 1'b0;
         if (n == glitch_at) begin
            bus.start     = 1'b1;
            bus.op        = ~op;
            bus.operand_a = 16'd9;
            bus.operand_b = 16'd3;
         end
         if (bus.done) break;
      end
      chk("latency", 32'(n), 32'(lat));
      chk("busy_at_done", 32'(bus.busy), 32'd0);
      chk("result", {bus.result_hi, bus.result_lo}, exp_r);
      chk("div_zero", 32'(bus.div_zero), 32'(exp_z));
      @(posedge clk); #1;
      chk("done_one_cycle", 32'(bus.done), 32'd0);
      chk("result_hold", {bus.result_hi, bus.result_lo}, exp_r);
   endtask

   initial begin
      logic [W-1:0] ra, rb;
      logic         rop;
      int           hits;
      rst_n         = 1'b0;
      bus.start     = 1'b0;
      bus.op        = OP_MUL;
      bus.operand_a = '0;
      bus.operand_b = '0;
`ifdef MULDIV_SIGNED_EN
      bus.op_signed = 1'b0;
`endif
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_div_zero", 32'(bus.div_zero), 32'd0);
      chk("rst_result", {bus.result_hi, bus.result_lo}, 32'd0);
      rst_n = 1'b1;

      run_op(OP_MUL, 16'hFFFF, 16'hFFFF, 1'b0, 0);
      run_op(OP_DIV, 16'd100, 16'd7, 1'b0, 0);
      run_op(OP_DIV, 16'h8000, 16'h0001, 1'b0, 0);
      run_op(OP_DIV, 16'h1234, 16'h0000, 1'b0, 0);
      run_op(OP_MUL, 16'd3, 16'd5, 1'b0, 0);
      run_op(OP_MUL, 16'd2, 16'd3, 1'b0, 5);
      run_op(OP_DIV, 16'hFFFF, 16'hFFFF, 1'b0, 0);
      run_op(OP_DIV, 16'd5, 16'd9, 1'b0, 0);

      // abort an operation in flight with reset
      @(negedge clk);
      bus.start     = 1'b1;
      bus.op        = OP_MUL;
      bus.operand_a = 16'd1234;
      bus.operand_b = 16'd77;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (7) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk("abort_busy", 32'(bus.busy), 32'd0);
      chk("abort_done", 32'(bus.done), 32'd0);
      chk("abort_div_zero", 32'(bus.div_zero), 32'd0);
      chk("abort_result", {bus.result_hi, bus.result_lo}, 32'd0);
      rst_n = 1'b1;
      hits  = 0;
      repeat (20) begin
         @(posedge clk); #1;
         if (bus.done) hits++;
      end
      chk("no_done_after_abort", 32'(hits), 32'd0);
      chk("abort_result_held", {bus.result_hi, bus.result_lo}, 32'd0);

      for (int i = 0; i < 40; i++) begin
         rop = 1'($urandom_range(0, 1));
         ra  = 16'($urandom);
         rb  = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 5)) : 16'($urandom);
         run_op(rop, ra, rb, 1'b0, 0);
      end

`ifdef MULDIV_SIGNED_EN
      run_op(OP_MUL, 16'hFFFA, 16'd7, 1'b1, 0);
      run_op(OP_DIV, 16'hFFF9, 16'd2, 1'b1, 0);
      run_op(OP_MUL, 16'hFFFA, 16'd7, 1'b0, 0);
      run_op(OP_DIV, 16'h8000, 16'hFFFF, 1'b1, 0);
      run_op(OP_DIV, 16'hFFF9, 16'h0000, 1'b1, 0);
      for (int i = 0; i < 30; i++) begin
         rop = 1'($urandom_range(0, 1));
         ra  = 16'($urandom);
         rb  = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom);
         run_op(rop, ra, rb, 1'b1, 0);
      end
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
